// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0] NOP_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   in_xfer;
    logic   out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (in_xfer) state_next = FULL;
            FULL: begin
                if (out_xfer && !in_xfer) begin
                    state_next = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                end else if (in_xfer && !out_xfer) begin
                    state_next = SKID;
`endif
                end
            end
            SKID:    if (out_xfer) state_next = FULL;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != EMPTY);
        occupancy = state;
`ifdef PIPE_STAGE_SKID_EN
        // Registered ready: depends only on the skid flop, never on out_ready.
        in_ready  = (state != SKID) && !rst;
`else
        in_ready  = !rst && ((state == EMPTY) || out_ready);
`endif
    end

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data;

    always_ff @(posedge clk) begin
        if (!rst && !flush && state == FULL && in_xfer && !out_xfer) begin
            skid_data <= in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= RESET_VAL;
        end else if (flush) begin
            out_data <= NOP_VAL;
`ifdef PIPE_STAGE_SKID_EN
        end else if (state == SKID) begin
            if (out_xfer) out_data <= skid_data;
`endif
        end else if (in_xfer && (state == EMPTY || out_xfer)) begin
            out_data <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table, scoreboard and corner sequences for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W   (DW),
        .RESET_VAL(16'h0000),
        .NOP_VAL  (16'h0013)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .occupancy(occupancy)
    );

    typedef struct {
        logic          rst;
        logic          flush;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t          vecs[11];
    logic [DW-1:0] q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_in;
    int            n_out;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observes one cycle at the negedge: pops on output transfer, pushes on input transfer.
    task automatic sb_cycle();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra actual=%0h expected=none", out_data);
            end else begin
                chk("sb_data", 32'(out_data), 32'(q.pop_front()));
            end
        end
        if (in_valid && in_ready) begin
            n_in++;
            q.push_back(in_data);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) sb_cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_ov", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        prev_stall = 1'b0; prev_data = '0;

        //          rst flush iv d       ordy ir ov od       occ
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 1'b1, 16'h0011, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b1, 1'b1, 16'h0022, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b1, 16'h0033, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0033, 2'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0044, 1'b0, 1'b1, 1'b1, 16'h0044, 2'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0066, 1'b0, 1'b1, 1'b1, 16'h0066, 2'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0099, 1'b1, 1'b1, 1'b0, 16'h0013, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0013, 2'd0};

        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_data = vecs[i].d; out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            tick();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

        // Backpressure: 0xA held, 0xB offered while downstream stalls.
        in_valid = 1'b1; in_data = 16'h000A; out_ready = 1'b0;
        tick();
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        chk("bp_a_data", 32'(out_data), 32'h0A);
        in_data = 16'h000B;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_hold_a", 32'(out_data), 32'h0A);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_b_data", 32'(out_data), 32'h0B);
        chk("bp_occ1", 32'(occupancy), 32'd1);
        tick();
`else
        chk("bp_b_blocked", 32'(in_ready), 32'd0);
        tick();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        chk("bp_hold_a", 32'(out_data), 32'h0A);
        out_ready = 1'b1;
        #1;
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_b_data", 32'(out_data), 32'h0B);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
`endif
        chk("bp_occ0", 32'(occupancy), 32'd0);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);

        // Flush at maximum occupancy with a concurrent input.
        in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b0;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 16'h0088;
        tick();
        chk("fl_occ_max", 32'(occupancy), 32'd2);
`else
        chk("fl_occ_max", 32'(occupancy), 32'd1);
`endif
        flush = 1'b1; in_data = 16'h0099;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_nop", 32'(out_data), 32'h13);
        chk("fl_occ", 32'(occupancy), 32'd0);
        tick();
        chk("fl_no_99_valid", 32'(out_valid), 32'd0);
        chk("fl_no_99_data", 32'(out_data), 32'h13);

        // Throughput with both sides always ready.
        q.delete(); n_in = 0; n_out = 0; prev_stall = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            in_data = 16'(k + 16'h0100);
            sb_cycle();
        end
        chk("tp_in", 32'(n_in), 32'd50);
        chk("tp_out", 32'(n_out), 32'd49);
        drain();

        // Random valid/ready with scoreboard.
        q.delete(); n_in = 0; n_out = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 20000 && n_in < 1000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            sb_cycle();
        end
        chk("rnd_accepted", 32'(n_in), 32'd1000);
        drain();
        chk("rnd_delivered", 32'(n_out), 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register; generic successor to the fixed IF/ID register.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, ...) and carries an opaque DATA_W-bit payload.
- Adds a valid/ready handshake, backpressure, flush with bubble insertion, and an optional skid buffer for full throughput with a registered ready.

Parameters:
DATA_W, 64, payload width in bits (IF/ID use: ia_plus_4 concatenated with ir)
RESET_VAL, '0, DATA_W-bit value loaded into out_data on reset
NOP_VAL, '0, DATA_W-bit bubble value loaded into out_data on flush

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream stage presents in_data
in_ready  out  1  this register accepts in_data this cycle
in_data  in  DATA_W  payload from upstream stage
out_valid  out  1  out_data holds a live payload
out_ready  in  1  downstream stage consumes out_data this cycle
out_data  out  DATA_W  payload to downstream stage
flush  in  1  discard all held and incoming payloads
occupancy  out  2  live entries held: 0, 1 or 2 (2 only with skid)

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - Both are evaluated on the same edge.
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=RESET_VAL, skid entry invalid, occupancy=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer drops the payload silently.
- Priority: rst > flush > normal operation.
- Flush (flush=1, rst=0):
  - Next edge: out_valid=0, out_data=NOP_VAL, skid invalid, occupancy=0.
  - An input transfer in the same cycle is consumed and discarded; it never appears at the output.
  - An output transfer in the same cycle still completes, because downstream sampled it.
- State machine (occupancy):
  - EMPTY(0): input transfer -> FULL; out_data<=in_data.
  - FULL(1), output and input transfer together -> FULL; out_data<=in_data. This is zero-bubble throughput.
  - FULL(1), output transfer only -> EMPTY; out_data holds its last value.
  - FULL(1), input transfer only -> SKID (skid build only); skid<=in_data.
  - FULL(1), neither -> FULL, hold.
  - SKID(2): output transfer -> FULL; out_data<=skid. Input cannot occur because in_ready=0.
  - SKID(2), no output transfer -> hold.
- Ordering: strict FIFO; no payload is duplicated or reordered.
- out_data is never modified while out_valid=1 && out_ready=0.
- Latency: 1 cycle from input transfer to out_valid when EMPTY.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - 2-entry operation (EMPTY/FULL/SKID).
  - in_ready = !skid_valid && !rst, driven directly from flops with no combinational path from out_ready.
  - Sustains 1 transfer/cycle.
  - occupancy reaches 2.
- Undefined:
  - No skid storage; SKID state is unreachable.
  - in_ready = !rst && (!out_valid || out_ready), combinational from out_ready.
  - occupancy is at most 1.
  - The FULL row "input transfer only" cannot occur.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/stream: hold rst 2 cycles.
  - During reset: out_valid=0, out_data=0, in_ready=0.
  - Then stream 0x11,0x22,0x33 with out_ready=1 -> out_data shows 0x11,0x22,0x33 on consecutive cycles, one cycle after each input transfer.
- Backpressure (skid build): out_valid with 0xA, out_ready=0, offer 0xB.
  - 0xB is accepted; occupancy=2; in_ready=0; out_data stays 0xA.
  - Raise out_ready -> 0xA, then 0xB; occupancy 2->1->0.
- Backpressure (non-skid build): same stimulus.
  - in_ready=0 while out_ready=0; 0xB is held upstream.
  - 0xB is accepted on the cycle out_ready rises.
- Flush with NOP_VAL=0x13: occupancy=2, assert flush together with in_valid=1, in_data=0x99.
  - Next cycle: out_valid=0, out_data=0x13, occupancy=0.
  - 0x99 never appears.
- Reset priority: assert rst and flush together while FULL.
  - out_data=RESET_VAL, not NOP_VAL; out_valid=0.
- Random valid/ready: 1000 random payloads with random in_valid/out_ready.
  - Scoreboard shows exact in-order delivery.
  - out_data is stable while stalled.
  - Throughput is 1/cycle when both sides are always ready.
